// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering MemRead/MemWrite with programmable wait states
module data_mem_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int WAIT_CYCLES = 2,
  parameter INIT_FILE = "dmem.hex"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              MemBusy,
  output logic              MemErr
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WLOAD = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
  state_t state, nxt;
  logic [3:0] cnt;
  logic rd_q, wr_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic c_rd, c_wr, c_err, fire, req;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wd;
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  always_comb begin
    req = MemRead | MemWrite;
    c_rd = state == IDLE ? MemRead : rd_q;
    c_wr = state == IDLE ? MemWrite : wr_q;
    c_addr = state == IDLE ? Addr : addr_q;
    c_wd = state == IDLE ? WriteData : wd_q;
    c_err = (c_rd & c_wr) | (|c_addr[ADDR_W-1:DEPTH_LOG2]);
    nxt = state;
    if (state == IDLE) nxt = req ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE;
    else if (state == WAIT) nxt = cnt == 4'd0 ? RESP : WAIT;
    else nxt = IDLE;
    fire = nxt == RESP;
  end
  assign MemReady = state == RESP;
  assign MemBusy = state != IDLE;
  assign MemErr = MemReady & err_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wd_q <= '0;
      ReadData <= '0;
    end else begin
      state <= nxt;
      cnt <= state == IDLE ? WLOAD : (cnt != 4'd0 ? cnt - 4'd1 : cnt);
      if (state == IDLE && req) begin
        rd_q <= MemRead;
        wr_q <= MemWrite;
        addr_q <= Addr;
        wd_q <= WriteData;
      end
      if (fire) err_q <= c_err;
      if (fire && c_rd) ReadData <= c_err ? '0 : mem[c_addr[DEPTH_LOG2-1:0]];
    end
  end
  always_ff @(posedge clk)
    if (rst && fire && c_wr && !c_err) mem[c_addr[DEPTH_LOG2-1:0]] <= c_wd;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized self-checking bench for data_mem_responder (WAIT_CYCLES=2 and 0)
module tb_data_mem_responder;
  logic clk = 0, rst = 0;
  logic rd = 0, wr = 0;
  logic [15:0] addr = 0, wd = 0;
  logic [15:0] rdata;
  logic rdy, busy, err;
  logic z_rd = 0, z_wr = 0;
  logic [15:0] z_addr = 0, z_wd = 0;
  logic [15:0] z_rdata;
  logic z_rdy, z_busy, z_err;
  int nt = 0, nf = 0;
  logic [15:0] mdl [256];
  logic [15:0] last_rd = 0;
  always #5 clk = ~clk;
  data_mem_responder dut (.clk(clk), .rst(rst), .MemRead(rd), .MemWrite(wr), .Addr(addr),
    .WriteData(wd), .ReadData(rdata), .MemReady(rdy), .MemBusy(busy), .MemErr(err));
  data_mem_responder #(.WAIT_CYCLES(0)) dut_z (.clk(clk), .rst(rst), .MemRead(z_rd), .MemWrite(z_wr),
    .Addr(z_addr), .WriteData(z_wd), .ReadData(z_rdata), .MemReady(z_rdy), .MemBusy(z_busy), .MemErr(z_err));

  // Issue one request for one cycle, scramble Addr/WriteData while waiting, and observe the response.
  task automatic txn(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                     output int lat, output int bcnt, output logic e, output logic [15:0] q,
                     output logic [15:0] q_after, output logic tail_ok);
    @(negedge clk); rd = r; wr = w; addr = a; wd = d;
    @(negedge clk); rd = 0; wr = 0;
    lat = 1; bcnt = 0;
    while (!rdy && lat < 40) begin
      bcnt += int'(busy); addr = 16'($urandom); wd = 16'($urandom);
      @(negedge clk); lat++;
    end
    bcnt += int'(busy); e = err; q = rdata;
    @(negedge clk);
    tail_ok = !rdy && !err && !busy;
    q_after = rdata;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nt++; if ({rdata, rdy, busy, err} !== 19'd0) begin nf++; $display("FAIL reset_hold rdata=%h rdy=%b busy=%b err=%b want 0", rdata, rdy, busy, err); end
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nt++; if ({rdata, rdy, busy, err, z_rdata, z_rdy, z_busy, z_err} !== 38'd0) begin
        nf++; $display("FAIL reset_idle cyc=%0d rdata=%h rdy=%b busy=%b err=%b z_rdy=%b z_busy=%b want 0", i, rdata, rdy, busy, err, z_rdy, z_busy);
      end
    end
    last_rd = 0;
  endtask

  task automatic test_store_load();
    int lat, bc; logic e, t; logic [15:0] q, qa;
    txn(0, 1, 16'h0012, 16'hBEEF, lat, bc, e, q, qa, t); mdl[8'h12] = 16'hBEEF;
    nt++; if (lat !== 3 || e !== 0 || bc !== 3 || !t) begin nf++; $display("FAIL store_beef lat=%0d err=%b busy=%0d tail=%b want 3/0/3/1", lat, e, bc, t); end
    txn(1, 0, 16'h0012, 16'h0000, lat, bc, e, q, qa, t); last_rd = 16'hBEEF;
    nt++; if (lat !== 3 || e !== 0 || q !== 16'hBEEF) begin nf++; $display("FAIL load_beef lat=%0d err=%b rdata=%h want 3/0/beef", lat, e, q); end
    nt++; if (qa !== 16'hBEEF || !t) begin nf++; $display("FAIL load_hold rdata=%h tail=%b want beef/1", qa, t); end
  endtask

  task automatic test_zero_wait();
    logic [15:0] v = 16'($urandom);
    @(negedge clk); z_wr = 1; z_addr = 16'h0007; z_wd = v;
    @(negedge clk); z_wr = 0; z_wd = ~v;
    nt++; if (z_rdy !== 1 || z_busy !== 1 || z_err !== 0) begin nf++; $display("FAIL z_store rdy=%b busy=%b err=%b want 1/1/0", z_rdy, z_busy, z_err); end
    @(negedge clk);
    nt++; if (z_rdy !== 0 || z_busy !== 0) begin nf++; $display("FAIL z_store_tail rdy=%b busy=%b want 0/0", z_rdy, z_busy); end
    z_rd = 1;
    @(negedge clk); z_rd = 0; z_addr = 16'h0003;
    nt++; if (z_rdy !== 1 || z_busy !== 1 || z_err !== 0 || z_rdata !== v) begin nf++; $display("FAIL z_load rdy=%b busy=%b err=%b rdata=%h want 1/1/0/%h", z_rdy, z_busy, z_err, z_rdata, v); end
    @(negedge clk);
    nt++; if (z_rdy !== 0 || z_busy !== 0 || z_rdata !== v) begin nf++; $display("FAIL z_load_tail rdy=%b busy=%b rdata=%h want 0/0/%h", z_rdy, z_busy, z_rdata, v); end
  endtask

  task automatic test_out_of_range();
    int lat, bc; logic e, t; logic [15:0] q, qa;
    logic [15:0] v0 = 16'($urandom);
    txn(0, 1, 16'h0000, v0, lat, bc, e, q, qa, t); mdl[0] = v0;
    txn(0, 1, 16'h0100, 16'h1234, lat, bc, e, q, qa, t);
    nt++; if (lat !== 3 || e !== 1 || !t || q !== last_rd) begin nf++; $display("FAIL oob_store lat=%0d err=%b tail=%b rdata=%h want 3/1/1/%h", lat, e, t, q, last_rd); end
    txn(1, 0, 16'h0000, 16'h0000, lat, bc, e, q, qa, t); last_rd = v0;
    nt++; if (e !== 0 || q !== v0) begin nf++; $display("FAIL oob_alias err=%b rdata=%h want 0/%h", e, q, v0); end
    txn(1, 0, 16'h8003, 16'h0000, lat, bc, e, q, qa, t); last_rd = 0;
    nt++; if (lat !== 3 || e !== 1 || q !== 16'h0000) begin nf++; $display("FAIL oob_load lat=%0d err=%b rdata=%h want 3/1/0", lat, e, q); end
  endtask

  task automatic test_illegal();
    int lat, bc, n; logic e, t, seen; logic [15:0] q, qa;
    logic [15:0] v = 16'($urandom), x = 16'($urandom), y = 16'($urandom);
    txn(0, 1, 16'h0020, v, lat, bc, e, q, qa, t); mdl[8'h20] = v;
    txn(1, 1, 16'h0020, ~v, lat, bc, e, q, qa, t); last_rd = 0;
    nt++; if (lat !== 3 || e !== 1 || q !== 16'h0000 || !t) begin nf++; $display("FAIL both_err lat=%0d err=%b rdata=%h tail=%b want 3/1/0/1", lat, e, q, t); end
    txn(1, 0, 16'h0020, 16'h0000, lat, bc, e, q, qa, t); last_rd = v;
    nt++; if (e !== 0 || q !== v) begin nf++; $display("FAIL both_nowrite err=%b rdata=%h want 0/%h", e, q, v); end
    txn(0, 1, 16'h0031, y, lat, bc, e, q, qa, t); mdl[8'h31] = y;
    // Store to 0x30 while a second store to 0x31 is held through WAIT and dropped on the ready cycle.
    @(negedge clk); wr = 1; addr = 16'h0030; wd = x;
    @(negedge clk); addr = 16'h0031; wd = ~y;
    n = 0;
    while (!rdy && n < 40) begin @(negedge clk); n++; end
    wr = 0; mdl[8'h30] = x;
    nt++; if (n >= 40) begin nf++; $display("FAIL held_ready timeout cycles=%0d want <40", n); end
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= busy | rdy; end
    nt++; if (seen !== 0) begin nf++; $display("FAIL held_serviced busy_or_ready=%b want 0", seen); end
    txn(1, 0, 16'h0030, 16'h0000, lat, bc, e, q, qa, t); last_rd = x;
    nt++; if (q !== x) begin nf++; $display("FAIL held_first rdata=%h want %h", q, x); end
    txn(1, 0, 16'h0031, 16'h0000, lat, bc, e, q, qa, t); last_rd = y;
    nt++; if (q !== y) begin nf++; $display("FAIL held_second rdata=%h want %h", q, y); end
  endtask

  task automatic test_mid_reset();
    int lat, bc; logic e, t, seen; logic [15:0] q, qa;
    logic [15:0] old = 16'($urandom);
    txn(0, 1, 16'h0005, old, lat, bc, e, q, qa, t); mdl[5] = old;
    @(negedge clk); wr = 1; addr = 16'h0005; wd = 16'hAAAA;
    @(negedge clk); wr = 0; rst = 0;
    @(negedge clk);
    nt++; if ({rdata, rdy, busy, err} !== 19'd0) begin nf++; $display("FAIL midrst_out rdata=%h rdy=%b busy=%b err=%b want 0", rdata, rdy, busy, err); end
    rst = 1; last_rd = 0; seen = 0;
    repeat (5) begin @(negedge clk); seen |= rdy | busy; end
    nt++; if (seen !== 0) begin nf++; $display("FAIL midrst_ready ready_or_busy=%b want 0", seen); end
    txn(1, 0, 16'h0005, 16'h0000, lat, bc, e, q, qa, t); last_rd = old;
    nt++; if (q !== old || e !== 0) begin nf++; $display("FAIL midrst_nowrite rdata=%h err=%b want %h/0", q, e, old); end
  endtask

  task automatic test_random();
    int lat, bc; logic e, t, r, w, oob, bad; logic [15:0] q, qa, a, d, want;
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      txn(0, 1, 16'(i), d, lat, bc, e, q, qa, t); mdl[i] = d;
      nt++; if (lat !== 3 || e !== 0) begin nf++; $display("FAIL rnd_init i=%0d lat=%0d err=%b want 3/0", i, lat, e); end
    end
    for (int i = 0; i < 60; i++) begin
      int k = int'($urandom_range(0, 9));
      r = k <= 3 || k >= 8; w = (k >= 4 && k <= 8);
      oob = k == 9 || $urandom_range(0, 9) == 0;
      a = {oob ? 8'($urandom_range(1, 255)) : 8'h00, 4'h0, 4'($urandom)};
      d = 16'($urandom);
      bad = oob || (r && w);
      txn(r, w, a, d, lat, bc, e, q, qa, t);
      if (w && !bad) mdl[a[7:0]] = d;
      if (r) last_rd = bad ? 16'h0000 : mdl[a[7:0]];
      want = last_rd;
      nt++; if (lat !== 3 || bc !== 3 || e !== bad || !t) begin nf++; $display("FAIL rnd_hs i=%0d r=%b w=%b a=%h lat=%0d busy=%0d err=%b tail=%b want 3/3/%b/1", i, r, w, a, lat, bc, e, t, bad); end
      nt++; if (q !== want || qa !== want) begin nf++; $display("FAIL rnd_data i=%0d r=%b w=%b a=%h rdata=%h hold=%h want %h", i, r, w, a, q, qa, want); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_zero_wait();
    test_out_of_range();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
